// File: rtl/pwm_duty_meas.sv
// pwm_duty_meas: decodes an asynchronous PWM input into a duty code (high
// clks) and a rise-to-rise period, published with a 1-clk valid strobe.
// An input with no accepted edge for TIMEOUT clks is flagged as stuck.
//
// Optional feature: define PWM_MEAS_GLITCH_FILT_EN to accept a synchronized
// level only after 2 consecutive equal samples (pulses <2 clks ignored,
// latency 5 clks instead of 3).
//
// Ports:
//   clk       in   1        system clock
//   rst_n     in   1        asynchronous active-low reset
//   PWM_in    in   1        PWM input, asynchronous to clk
//   duty      out  CNT_W    measured high clks, saturated at 2**CNT_W-1
//   period    out  CNT_W+1  measured rise-to-rise clks, saturated at all-ones
//   duty_vld  out  1        1-clk pulse when duty/period update
//   stuck     out  1        high while the input is declared stuck
module pwm_duty_meas #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM_in,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W:0]   period,
  output logic             duty_vld,
  output logic             stuck
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0]    CNT_MAX   = '1;
  localparam logic [CNT_W:0]    CNT_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0]  DUTY_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic [CNT_W:0]    r_hi_cnt;
  logic [CNT_W:0]    r_per_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0]  r_duty;
  logic [CNT_W:0]    r_period;
  logic              r_duty_vld;
  logic              r_stuck;

  logic w_lvl;
  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_timeout;

  // Two-flop synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= PWM_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_MEAS_GLITCH_FILT_EN
  logic r_sync3;
  logic r_filt;

  // Level accepted only after two consecutive equal synchronized samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync3 <= 1'b0;
      r_filt  <= 1'b0;
    end else begin
      r_sync3 <= r_sync2;
      if (r_sync2 == r_sync3) r_filt <= r_sync2;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync2;
`endif

  // Previous accepted level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_lvl;
  end

  assign w_rise    = w_lvl & ~r_prev;
  assign w_fall    = ~w_lvl & r_prev;
  assign w_edge    = w_rise | w_fall;
  // An edge in the same clk as the timeout wins; no re-trigger while stuck
  assign w_timeout = (r_state != ST_STUCK) && !w_edge && (r_idle_cnt == IDLE_LAST);

  // Measurement counters, state machine and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hi_cnt   <= '0;
      r_per_cnt  <= '0;
      r_idle_cnt <= '0;
      r_duty     <= '0;
      r_period   <= '0;
      r_duty_vld <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_duty_vld <= 1'b0;

      // High/period counters restart on a rise and saturate, never wrap
      if (w_rise) begin
        r_hi_cnt  <= CNT_ONE;
        r_per_cnt <= CNT_ONE;
      end else begin
        if (r_per_cnt != CNT_MAX)          r_per_cnt <= r_per_cnt + CNT_ONE;
        if (w_lvl && (r_hi_cnt != CNT_MAX)) r_hi_cnt  <= r_hi_cnt + CNT_ONE;
      end

      if (w_edge)                       r_idle_cnt <= '0;
      else if (r_idle_cnt != IDLE_LAST) r_idle_cnt <= r_idle_cnt + IDLE_ONE;

      case (r_state)
        ST_IDLE: begin
          if (w_rise) r_state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (w_fall) r_state <= ST_LOW;
        end
        ST_LOW: begin
          if (w_rise) begin
            r_state    <= ST_HIGH;
            r_duty     <= r_hi_cnt[CNT_W] ? DUTY_MAX : r_hi_cnt[CNT_W-1:0];
            r_period   <= r_per_cnt;
            r_duty_vld <= 1'b1;
          end
        end
        ST_STUCK: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
            r_stuck <= 1'b0;
          end else if (w_fall) begin
            r_state <= ST_IDLE;
            r_stuck <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Timeout publishes the held level as 0% or 100% with a saturated period
      if (w_timeout) begin
        r_state    <= ST_STUCK;
        r_stuck    <= 1'b1;
        r_duty     <= w_lvl ? DUTY_MAX : '0;
        r_period   <= CNT_MAX;
        r_duty_vld <= 1'b1;
      end
    end
  end

  assign duty     = r_duty;
  assign period   = r_period;
  assign duty_vld = r_duty_vld;
  assign stuck    = r_stuck;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// tb_pwm_duty_meas: directed PWM waveforms with hand-computed duty/period;
// expected publishes go into a queue that a negedge monitor pops on duty_vld.
// Level checks from the stimulus process are queued to the same monitor.
module tb_pwm_duty_meas;

  localparam int unsigned CNT_W = 10;

  logic             clk;
  logic             rst_n;
  logic             PWM_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W:0]   period;
  logic             duty_vld;
  logic             stuck;

  typedef struct {
    int d;
    int p;
    int s;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];

  int n_vec = 0;
  int n_err = 0;

  int have_prev = 0;
  int prev_d    = 0;
  int prev_p    = 0;

  pwm_duty_meas #(.CNT_W(CNT_W), .TIMEOUT(2048)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PWM_in   (PWM_in),
    .duty     (duty),
    .period   (period),
    .duty_vld (duty_vld),
    .stuck    (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sole owner of the counters
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      n_vec++;
      if (c.act != c.exp) begin
        n_err++;
        $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.exp);
      end
    end
    if (rst_n && duty_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_vld: got duty=%0d period=%0d, expected no publish",
                 duty, period);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec += 3;
        if (int'(duty) != e.d) begin
          n_err++;
          $display("FAIL duty: got %0d, expected %0d", duty, e.d);
        end
        if (int'(period) != e.p) begin
          n_err++;
          $display("FAIL period: got %0d, expected %0d", period, e.p);
        end
        if (int'(stuck) != e.s) begin
          n_err++;
          $display("FAIL stuck_at_vld: got %0d, expected %0d", stuck, e.s);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_exp(input int d, input int p, input int s);
    exp_t e;
    e.d = d;
    e.p = p;
    e.s = s;
    exp_q.push_back(e);
  endtask

  // Hold a level for exactly n sampling edges
  task automatic drive(input logic lvl, input int n);
    PWM_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PWM period; the previous period is published at this period's rise
  task automatic cyc(input int hi, input int per, input int ed, input int ep);
    if (have_prev != 0) push_exp(prev_d, prev_p, 0);
    drive(1'b1, hi);
    drive(1'b0, per - hi);
    prev_d    = ed;
    prev_p    = ep;
    have_prev = 1;
  endtask

  initial begin
    PWM_in = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_vld", int'(duty_vld), 0);
    chk("rst_stuck", int'(stuck), 0);
    rst_n = 1'b1;
    drive(1'b0, 10);

    // 50% duty, then duty sweep, then saturation
    for (int i = 0; i < 3; i++) cyc(512, 1024, 512, 1024);
`ifndef PWM_MEAS_GLITCH_FILT_EN
    cyc(1, 1024, 1, 1024);
`endif
    cyc(300, 1024, 300, 1024);
    cyc(1023, 1024, 1023, 1024);
    cyc(1023, 1024, 1023, 1024);
    cyc(1500, 3000, 1023, 2047);
    cyc(1500, 3000, 1023, 2047);
    have_prev = 0;

    // Held low -> stuck publish with duty 0, period all-ones
    push_exp(0, 2047, 1);
    drive(1'b0, 3000);
    chk("stuck_set", int'(stuck), 1);
    chk("stuck_duty", int'(duty), 0);
    chk("stuck_period", int'(period), 2047);

    // First rise leaves stuck without publishing; second rise publishes
    drive(1'b1, 10);
    chk("stuck_clear", int'(stuck), 0);
    drive(1'b0, 500);
    push_exp(10, 510, 0);
    drive(1'b1, 100);

    // Reset in the middle of a high phase
    rst_n = 1'b0;
    #1;
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_vld", int'(duty_vld), 0);
    chk("midrst_stuck", int'(stuck), 0);
    drive(1'b0, 5);
    rst_n = 1'b1;
    drive(1'b0, 10);

    for (int i = 0; i < 3; i++) cyc(200, 1024, 200, 1024);
`ifdef PWM_MEAS_GLITCH_FILT_EN
    // 1-clk glitch inside the low phase must be ignored
    push_exp(prev_d, prev_p, 0);
    drive(1'b1, 200);
    drive(1'b0, 400);
    drive(1'b1, 1);
    drive(1'b0, 423);
    prev_d = 200;
    prev_p = 1024;
`endif
    push_exp(prev_d, prev_p, 0);
    drive(1'b1, 5);
    drive(1'b0, 5);

    // Bounded wait for outstanding publishes
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("pending_publishes", exp_q.size(), 0);
    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
